// File: rtl/mov_if.sv
// mov_if: request, memory-port and status signals of the MIX MOVE engine.
interface mov_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 31,
  parameter int LEN_W = 6
);
  logic start;
  logic [ADDR_W-1:0] addressin;
  logic [ADDR_W-1:0] addressdst;
  logic [LEN_W-1:0] len;
  logic [DATA_W-1:0] datain;
  logic [ADDR_W-1:0] addressout;
  logic load;
  logic [ADDR_W-1:0] addresswr;
  logic [DATA_W-1:0] dataout;
  logic store;
  logic [ADDR_W-1:0] dstout;
  logic busy;
  logic done;
  modport master (
    output start, addressin, addressdst, len, datain,
    input addressout, load, addresswr, dataout, store, dstout, busy, done
  );
  modport slave (
    input start, addressin, addressdst, len, datain,
    output addressout, load, addresswr, dataout, store, dstout, busy, done
  );
endinterface

// File: rtl/mov.sv
// mov: MIX MOVE block copier over a registered-read memory port.
// Define MOV_PIPELINE_EN to overlap each read with the previous word's write.
module mov #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 31,
  parameter int LEN_W = 6
) (
  input logic clk,
  input logic rst_n,
  mov_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
`ifdef MOV_PIPELINE_EN
  localparam logic PIPE = 1'b1;
`else
  localparam logic PIPE = 1'b0;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, dstout_q, dstout_d;
  logic [LEN_W-1:0] len_q, len_d, i_q, i_d;
  logic more;
  always_comb begin
    more = i_q + LEN_W'(1) < len_q;
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    i_d = i_q;
    dstout_d = dstout_q;
    case (state_q)
      IDLE: if (bus.start) begin
        src_d = bus.addressin;
        dst_d = bus.addressdst;
        len_d = bus.len;
        i_d = '0;
        dstout_d = bus.addressdst + ADDR_W'(bus.len);
        state_d = bus.len == '0 ? FIN : READ;
      end
      READ: state_d = WRITE;
      WRITE: begin
        i_d = i_q + LEN_W'(1);
        state_d = !more ? FIN : PIPE ? WRITE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      i_q <= '0;
      dstout_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      i_q <= i_d;
      dstout_q <= dstout_d;
    end
  end
  // in pipelined WRITE the read runs one word ahead of the write
  assign bus.load = state_q == READ || (PIPE && state_q == WRITE && more);
  assign bus.addressout = src_q + ADDR_W'(i_q) + ADDR_W'(PIPE && state_q == WRITE);
  assign bus.store = state_q == WRITE;
  assign bus.addresswr = dst_q + ADDR_W'(i_q);
  assign bus.dataout = DATA_W'(bus.datain);
  assign bus.dstout = dstout_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FIN;
endmodule

// File: tb/tb_mov.sv
// tb_mov: randomized and directed checks of mov against a word-copy model.
module tb_mov;
  localparam int AW = 12, DW = 31, LW = 6;
`ifdef MOV_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mov_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();
  mov #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ref_mem [4096];
  logic bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  int n_pass = 0, n_tot = 0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.load) bus.datain <= mem[bus.addressout];
    if (bus.store) mem[bus.addresswr] <= bus.dataout;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  function automatic int done_cycle(input int n);
    return PIPE ? (n == 0 ? 1 : n + 2) : 2 * n + 1;
  endfunction
  task automatic cycle_chk(input int src, input int dst, input int n, input int c);
    bit el, es;
    int ra, wa;
    el = PIPE ? (c <= n) : (c <= 2 * n && c % 2 == 1);
    es = PIPE ? (c >= 2 && c <= n + 1) : (c <= 2 * n && c % 2 == 0);
    ra = PIPE ? src + c - 1 : src + (c - 1) / 2;
    wa = PIPE ? dst + c - 2 : dst + (c - 2) / 2;
    chk("busy", bus.busy, 1);
    chk("done", bus.done, 64'(c == done_cycle(n)));
    chk("load", bus.load, 64'(el));
    chk("store", bus.store, 64'(es));
    if (el) chk("raddr", bus.addressout, 64'(ra & 4095));
    if (es) chk("waddr", bus.addresswr, 64'(wa & 4095));
  endtask
  task automatic model_copy(input int src, input int dst, input int n);
    for (int k = 0; k < n; k++) ref_mem[(dst + k) & 4095] = ref_mem[(src + k) & 4095];
  endtask
  task automatic mem_chk();
    int errs = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== ref_mem[a]) errs++;
    chk("mem_all", errs, 0);
  endtask
  task automatic run_move(input int src, input int dst, input int n);
    int ed;
    ed = done_cycle(n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addressin = AW'(src);
    bus.addressdst = AW'(dst);
    bus.len = LW'(n);
    @(negedge clk);
    for (int c = 1; c <= ed; c++) begin
      cycle_chk(src, dst, n, c);
      if (c == ed) chk("dstout", bus.dstout, 64'((dst + n) & 4095));
      bus.start = c == ed;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_load", bus.load, 0);
    model_copy(src, dst, n);
    mem_chk();
  endtask
  initial begin
    int src, dst, n;
    bus.start = 1'b0;
    bus.addressin = '0;
    bus.addressdst = '0;
    bus.len = '0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = DW'($urandom);
    ref_mem[100] = DW'(12345);
    ref_mem[101] = DW'(1245);
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      bd_we = 1'b1;
      bd_addr = AW'(a);
      bd_data = ref_mem[a];
    end
    @(negedge clk);
    bd_we = 1'b0;
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load", bus.load, 0);
    chk("rst_store", bus.store, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_raddr", bus.addressout, 0);
    chk("rst_waddr", bus.addresswr, 0);
    chk("rst_dstout", bus.dstout, 0);
    run_move(100, 300, 8);
    chk("mem300", mem[300], 12345);
    chk("mem301", mem[301], 1245);
    chk("dst308", bus.dstout, 308);
    run_move(5, 77, 0);
    run_move(4094, 4095, 3);
    run_move(500, PIPE ? 502 : 501, 6);
    run_move(600, 597, 7);
    // restart attempt mid-move, then asynchronous reset
    @(negedge clk);
    bus.start = 1'b1;
    bus.addressin = AW'(10);
    bus.addressdst = AW'(20);
    bus.len = LW'(5);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.start = 1'b1;
        bus.addressin = AW'(999);
      end else bus.start = 1'b0;
      cycle_chk(10, 20, 5, c);
    end
    @(negedge clk);
    cycle_chk(10, 20, 5, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_load", bus.load, 0);
    chk("arst_store", bus.store, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("arst_done", bus.done, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_busy", bus.busy, 0);
      chk("post_done", bus.done, 0);
    end
    model_copy(10, 20, PIPE ? 3 : 2);
    mem_chk();
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 12);
      src = $urandom_range(0, 4095);
      dst = $urandom_range(0, 1) ? (src + $urandom_range(0, 20) + 4086) & 4095 : $urandom_range(0, 4095);
      if (PIPE && dst == ((src + 1) & 4095)) dst = (dst + 1) & 4095;
      run_move(src, dst, n);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mov.md
MOV -- requirements
Module: mov

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (MIX 4000-word memory).
REQ-002 Parameter DATA_W, default 31, word width (sign + 5 bytes x 6 bits).
REQ-003 Parameter LEN_W, default 6, width of word count (MIX F field, 0..63).
REQ-004 clk  in  1  single system clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a move.
REQ-007 addressin  in  ADDR_W  source start address (MIX M).
REQ-008 addressdst  in  ADDR_W  destination start address (MIX rI1).
REQ-009 len  in  LEN_W  number of words to copy.
REQ-010 datain  in  DATA_W  read data; valid the cycle after the one in which load was high (registered memory).
REQ-011 addressout  out  ADDR_W  read address, meaningful while load=1.
REQ-012 load  out  1  read strobe.
REQ-013 addresswr  out  ADDR_W  write address, meaningful while store=1.
REQ-014 dataout  out  DATA_W  write data; combinational copy of datain.
REQ-015 store  out  1  write strobe.
REQ-016 dstout  out  ADDR_W  updated destination (addressdst+len mod 2^ADDR_W), valid from done onward.
REQ-017 busy  out  1  high while a move is in progress.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 start, addressin, addressdst and len are sampled on the rising edge where start=1 and busy=0; start while busy=1 is ignored.
REQ-020 States: IDLE, READ, WRITE, FIN; IDLE->READ on accepted start with len>0, IDLE->FIN on accepted start with len=0.
REQ-021 READ (one cycle): load=1, addressout=src+i; next state WRITE.
REQ-022 WRITE (one cycle): store=1, addresswr=dst+i, dataout=datain; i increments; next state READ if i+1<len, else FIN.
REQ-023 FIN (one cycle): done=1, dstout updated, busy=0 in the following cycle; next state IDLE.
REQ-024 busy=1 in READ, WRITE, FIN; load and store are never high in IDLE or FIN.
REQ-025 Latency (non-pipelined): first load in the cycle after start is accepted; done 2*len+1 cycles after accept; len=0 gives done 1 cycle after accept with no load/store.
REQ-026 Address arithmetic modulo 2^ADDR_W; src+i and dst+i wrap silently (4095+1 -> 0).
REQ-027 Word data passes unmodified (all DATA_W bits, sign included); overlapping ranges are copied in ascending address order.
REQ-028 start coincident with done is ignored (busy still 1).

Reset
REQ-029 rst_n=0 forces IDLE immediately, regardless of clk, including mid-move (move abandoned, no done).
REQ-030 Reset values: load=0, store=0, busy=0, done=0, addressout=0, addresswr=0, dstout=0, word counter=0.
REQ-031 First accepted start is the first rising edge with rst_n=1 and start=1.

Configuration
REQ-032 Macro MOV_PIPELINE_EN: when defined, read and write overlap -- load high for cycles 1..len after accept (addressout=src+k-1), store high for cycles 2..len+1 (addresswr=dst+k-2), one word per cycle, done at cycle len+2 (len=0: cycle 1).
REQ-033 Without MOV_PIPELINE_EN, the alternating READ/WRITE behaviour of REQ-020..REQ-025 applies; all other requirements are identical in both builds.

Verification
REQ-034 rst_n low then high, idle -> load=0, store=0, busy=0, done=0, addressout=0.
REQ-035 addressin=100, addressdst=300, len=8, mem[100]=12345, mem[101]=1245, start pulse 2 cycles -> reads 100..107, writes 300..307, mem[300]=12345, mem[301]=1245, done once, dstout=308.
REQ-036 len=0, start -> done 1 cycle after accept, no load or store, dstout=addressdst.
REQ-037 addressin=4094, addressdst=4095, len=3 -> read addresses 4094,4095,0; write addresses 4095,0,1.
REQ-038 start re-pulsed mid-move, then rst_n pulsed low mid-move -> second start ignored; reset returns IDLE asynchronously, no done.
REQ-039 Repeat REQ-035 with MOV_PIPELINE_EN -> same memory result, done 10 cycles after accept.
